spi_slave_rx: RTL and testbench
===============================

// Module: spi_slave_rx
// PURPOSE
//  Receive side of the SPI link; sits directly downstream of spi_master on the same clk.
//  Samples sclk/mosi/cs_n and recovers each frame: one R/W direction bit, then data words LSB first.
//  Words pass into a small FIFO and leave on a valid/ready port toward the register/bus side.
// PARAMETERS
//  DATA_BYTE   1  bytes per data word; DATA_BIT = 8*DATA_BYTE
//  FIFO_DEPTH  2  word FIFO entries, power of 2, >=2
// PORTS
//  clk        in   1         system clock; only clock in the block
//  rst        in   1         asynchronous, active-high reset
//  i_cs_n     in   1         slave select, active low; frame = low interval
//  i_sclk     in   1         SPI clock from master; high pulse >=1 clk, low >=1 clk
//  i_mosi     in   1         serial data, stable while i_sclk high
//  o_dir      out  1         captured direction bit (1 write, 0 read)
//  o_dir_vld  out  1         1-cycle pulse when o_dir is captured
//  o_data     out  DATA_BIT  FIFO head word
//  o_data_vld out  1         FIFO non-empty
//  i_data_rdy in   1         consumer pops head when o_data_vld & i_data_rdy
//  o_busy     out  1         frame in progress (FSM not IDLE)
//  o_frm_end  out  1         1-cycle pulse when a frame closes (cs_q rises while not IDLE)
//  o_word_cnt out  8         words completed in current/last frame, saturates at 255
//  o_ovf      out  1         sticky overflow flag
//  i_ovf_clr  in   1         clears o_ovf
// BEHAVIOUR
//  Reset: all outputs 0, FSM IDLE, FIFO empty, input regs cs_q=1, sclk_q=sclk_d=mosi_q=0.
//  Input stage: cs_q, sclk_q, mosi_q registered once; sclk_d = sclk_q delayed 1.
//   rise = sclk_q & !sclk_d & !cs_q; all sampling uses mosi_q in the rise cycle.
//  FSM states IDLE, DIR, DATA:
//   IDLE: cs_q==0 -> DIR; clear bit_cnt, shift reg, o_word_cnt.
//   DIR : on rise: o_dir<=mosi_q, o_dir_vld pulses next cycle -> DATA.
//   DATA: on rise: shift={mosi_q,shift[DATA_BIT-1:1]} (LSB first); bit_cnt++.
//         On rise with bit_cnt==DATA_BIT-1: push word, bit_cnt<=0, o_word_cnt+1 (sat 255), stay DATA.
//         Inter-word pause = no rises; no timeout.
//   Any state but IDLE: cs_q==1 -> IDLE, o_frm_end pulse; partial word discarded, no push.
//   cs_q rise and rise in same cycle: cs_q wins (rise is already masked).
//  Latency: last-bit rise in cycle E -> word in FIFO, o_data_vld=1 in cycle E+1 (if FIFO was empty).
//  FIFO: push accepted if not full, or full with pop in the same cycle.
//   Push while full and no pop: word dropped, o_ovf<=1. Set and i_ovf_clr same cycle: set wins.
//   FIFO is NOT flushed by cs_n; only rst clears it. o_data holds while vld & !rdy.
//  o_dir holds until the next DIR capture; o_word_cnt holds after frame end until next frame start.
//  rst mid-frame: immediate return to reset state; the next frame needs a fresh cs_n fall.
// STRUCTURE
//  spi_pkg: spi_rx_state_e {IDLE,DIR,DATA}, SPI_DIR_WR=1'b1, SPI_DIR_RD=1'b0.
//  Sub-module spi_rx_fifo (sync FIFO, DATA_BIT x FIFO_DEPTH, push/pop/full/empty).
//  Top holds input regs, edge detect, FSM, counters, ovf flag.
// TESTING
//  1 frame, dir=1, data 0xA5 LSB first, rdy=1 -> o_dir_vld once with o_dir=1; o_data=0xA5 one cycle; cnt=1.
//  3 words 0x01,0x80,0xFF with pauses, rdy=0 -> after 2 words FIFO full; 3rd dropped, o_ovf=1;
//    pops yield 0x01,0x80.
//  cs_n high after 5 bits of the 2nd word -> o_frm_end pulse, only word 1 in FIFO, o_word_cnt=1.
//  Full FIFO, last-bit rise in the same cycle as pop -> no ovf, order preserved.
//  rst pulse mid-word -> all outputs 0; next full frame with 0x3C received correctly.
//  Master spi_master (clk/2 sclk, DATA_BYTE=2, dir=0, 0x1234) -> o_dir=0, o_data=0x1234.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI receive slice.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIR  = 2'd1,
    DATA = 2'd2
  } spi_rx_state_e;

  localparam logic SPI_DIR_WR = 1'b1;
  localparam logic SPI_DIR_RD = 1'b0;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/spi_rx_fifo.sv
// Small synchronous word FIFO; a push into a full FIFO is taken only when a pop
// happens in the same cycle.
module spi_rx_fifo
  import spi_pkg::*;
#(
  parameter int DATA_BIT = 8,
  parameter int DEPTH    = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_push,
  input  logic [DATA_BIT-1:0] i_wdata,
  input  logic                i_pop,
  output logic [DATA_BIT-1:0] o_rdata,
  output logic                o_full,
  output logic                o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]         r_wr_ptr;
  logic [AW:0]         r_rd_ptr;
  logic [DATA_BIT-1:0] r_mem [DEPTH];
  logic                w_full;
  logic                w_empty;
  logic                w_do_pop;
  logic                w_do_push;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_do_pop  = i_pop & ~w_empty;
  assign w_do_push = i_push & (~w_full | w_do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
        r_wr_ptr                <= r_wr_ptr + (AW+1)'(1);
      end
      if (w_do_pop) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  assign o_rdata = r_mem[r_rd_ptr[AW-1:0]];
  assign o_full  = w_full;
  assign o_empty = w_empty;

endmodule

// File: rtl/spi_slave_rx.sv
// SPI receive slave: oversamples sclk/mosi/cs_n on clk, recovers a direction bit
// followed by LSB-first data words, and queues the words toward a valid/ready port.
module spi_slave_rx
  import spi_pkg::*;
#(
  parameter int DATA_BYTE  = 1,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_cs_n,
  input  logic                   i_sclk,
  input  logic                   i_mosi,
  output logic                   o_dir,
  output logic                   o_dir_vld,
  output logic [8*DATA_BYTE-1:0] o_data,
  output logic                   o_data_vld,
  input  logic                   i_data_rdy,
  output logic                   o_busy,
  output logic                   o_frm_end,
  output logic [7:0]             o_word_cnt,
  output logic                   o_ovf,
  input  logic                   i_ovf_clr
);

  localparam int DATA_BIT = 8 * DATA_BYTE;
  localparam int CW       = $clog2(DATA_BIT);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_BIT - 1);

  spi_rx_state_e r_state, w_next;

  logic                r_cs_q;
  logic                r_sclk_q;
  logic                r_sclk_d;
  logic                r_mosi_q;
  logic [CW-1:0]       r_bit_cnt;
  logic [DATA_BIT-2:0] r_shift;
  logic [7:0]          r_word_cnt;
  logic                r_dir;
  logic                r_dir_vld;
  logic                r_frm_end;
  logic                r_ovf;

  logic                w_rise;
  logic                w_start;
  logic                w_dir_cap;
  logic                w_bit_en;
  logic                w_close;
  logic                w_push;
  logic                w_pop;
  logic                w_full;
  logic                w_empty;
  logic [DATA_BIT-1:0] w_word;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cs_q   <= 1'b1;
      r_sclk_q <= 1'b0;
      r_sclk_d <= 1'b0;
      r_mosi_q <= 1'b0;
    end else begin
      r_cs_q   <= i_cs_n;
      r_sclk_q <= i_sclk;
      r_sclk_d <= r_sclk_q;
      r_mosi_q <= i_mosi;
    end
  end

  // Deselect masks the edge, so a closing frame never takes a late bit.
  assign w_rise = r_sclk_q & ~r_sclk_d & ~r_cs_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_start   = 1'b0;
    w_dir_cap = 1'b0;
    w_bit_en  = 1'b0;
    w_close   = 1'b0;
    case (r_state)
      IDLE: begin
        if (!r_cs_q) begin
          w_next  = DIR;
          w_start = 1'b1;
        end
      end
      DIR: begin
        if (r_cs_q) begin
          w_next  = IDLE;
          w_close = 1'b1;
        end else if (w_rise) begin
          w_next    = DATA;
          w_dir_cap = 1'b1;
        end
      end
      DATA: begin
        if (r_cs_q) begin
          w_next  = IDLE;
          w_close = 1'b1;
        end else if (w_rise) begin
          w_bit_en = 1'b1;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // The final bit goes straight from mosi_q so the word is pushed in the last-bit cycle.
  assign w_push = w_bit_en && (r_bit_cnt == LAST_BIT);
  assign w_word = {r_mosi_q, r_shift};
  assign w_pop  = ~w_empty & i_data_rdy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_word_cnt <= '0;
      r_dir      <= SPI_DIR_RD;
      r_dir_vld  <= 1'b0;
      r_frm_end  <= 1'b0;
    end else begin
      r_dir_vld <= w_dir_cap;
      r_frm_end <= w_close;
      if (w_dir_cap) r_dir <= r_mosi_q;
      if (w_start) begin
        r_bit_cnt  <= '0;
        r_shift    <= '0;
        r_word_cnt <= '0;
      end else if (w_bit_en) begin
        r_shift <= {r_mosi_q, r_shift[DATA_BIT-2:1]};
        if (w_push) begin
          r_bit_cnt  <= '0;
          r_word_cnt <= sat_inc8(r_word_cnt);
        end else begin
          r_bit_cnt <= r_bit_cnt + CW'(1);
        end
      end
    end
  end

  // A new overflow outranks a clear arriving in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         r_ovf <= 1'b0;
    else if (w_push & w_full & ~w_pop) r_ovf <= 1'b1;
    else if (i_ovf_clr)              r_ovf <= 1'b0;
  end

  spi_rx_fifo #(
    .DATA_BIT (DATA_BIT),
    .DEPTH    (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_wdata (w_word),
    .i_pop   (w_pop),
    .o_rdata (o_data),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign o_dir      = r_dir;
  assign o_dir_vld  = r_dir_vld;
  assign o_data_vld = ~w_empty;
  assign o_busy     = (r_state != IDLE);
  assign o_frm_end  = r_frm_end;
  assign o_word_cnt = r_word_cnt;
  assign o_ovf      = r_ovf;

endmodule

// File: tb/tb_spi_slave_rx.sv
// Directed bench for spi_slave_rx: 8-bit instance for most scenarios, 16-bit
// instance driven like spi_master at clk/2.
module tb_spi_slave_rx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic csN = 1'b1;
  logic cs16N = 1'b1;
  logic sclk = 1'b0;
  logic mosi = 1'b0;
  logic dataRdy = 1'b0;
  logic dataRdy16 = 1'b0;
  logic ovfClr = 1'b0;

  logic        dir, dirVld, dataVld, busy, frmEnd, ovf;
  logic [7:0]  data, wordCnt;
  logic        dir16, dirVld16, dataVld16, busy16, frmEnd16, ovf16;
  logic [15:0] data16;
  logic [7:0]  wordCnt16;

  int checks = 0;
  int failures = 0;
  int dirVldCount = 0;
  int frmEndCount = 0;
  int dirBase, frmBase;

  always #5 clk = ~clk;

  spi_slave_rx #(.DATA_BYTE(1), .FIFO_DEPTH(2)) u_dut (
    .clk(clk), .rst(rst), .i_cs_n(csN), .i_sclk(sclk), .i_mosi(mosi),
    .o_dir(dir), .o_dir_vld(dirVld), .o_data(data), .o_data_vld(dataVld),
    .i_data_rdy(dataRdy), .o_busy(busy), .o_frm_end(frmEnd),
    .o_word_cnt(wordCnt), .o_ovf(ovf), .i_ovf_clr(ovfClr)
  );

  spi_slave_rx #(.DATA_BYTE(2), .FIFO_DEPTH(2)) u_dut16 (
    .clk(clk), .rst(rst), .i_cs_n(cs16N), .i_sclk(sclk), .i_mosi(mosi),
    .o_dir(dir16), .o_dir_vld(dirVld16), .o_data(data16), .o_data_vld(dataVld16),
    .i_data_rdy(dataRdy16), .o_busy(busy16), .o_frm_end(frmEnd16),
    .o_word_cnt(wordCnt16), .o_ovf(ovf16), .i_ovf_clr(1'b0)
  );

  always @(negedge clk) begin
    if (dirVld) dirVldCount++;
    if (frmEnd) frmEndCount++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic b, input logic popAtRise);
    mosi = b;
    sclk = 1'b1;
    tick();
    if (popAtRise) dataRdy = 1'b1;
    sclk = 1'b0;
    tick();
    if (popAtRise) dataRdy = 1'b0;
  endtask

  task automatic sendWord(input logic [15:0] word, input int n, input logic popLast);
    for (int i = 0; i < n; i++) applyStimulus(word[i], popLast && (i == n - 1));
  endtask

  task automatic startFrame();
    csN = 1'b0;
    repeat (3) tick();
  endtask

  task automatic endFrame();
    csN = 1'b1;
    repeat (2) tick();
  endtask

  initial begin
    $display("[TB] start");
    repeat (2) tick();
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_data_vld", dataVld, 0);
    checkOutput("rst_word_cnt", wordCnt, 0);
    checkOutput("rst_ovf", ovf, 0);
    checkOutput("rst_dir", dir, 0);
    rst = 1'b0;
    repeat (2) tick();

    // Single frame, write, 0xA5, consumer always ready
    dataRdy = 1'b1;
    dirBase = dirVldCount;
    frmBase = frmEndCount;
    startFrame();
    checkOutput("t1_busy", busy, 1);
    applyStimulus(1'b1, 1'b0);
    checkOutput("t1_dir_vld", dirVld, 1);
    checkOutput("t1_dir", dir, 1);
    sendWord(16'h00A5, 8, 1'b0);
    checkOutput("t1_data_vld", dataVld, 1);
    checkOutput("t1_data", data, 8'hA5);
    checkOutput("t1_cnt", wordCnt, 1);
    tick();
    checkOutput("t1_vld_one_cycle", dataVld, 0);
    endFrame();
    checkOutput("t1_frm_end", frmEnd, 1);
    checkOutput("t1_busy_end", busy, 0);
    tick();
    checkOutput("t1_frm_end_pulse", frmEnd, 0);
    checkOutput("t1_cnt_hold", wordCnt, 1);
    checkOutput("t1_dir_vld_once", dirVldCount - dirBase, 1);
    checkOutput("t1_frm_end_once", frmEndCount - frmBase, 1);

    // Three words into a two-deep FIFO with no consumer
    dataRdy = 1'b0;
    startFrame();
    checkOutput("t2_cnt_cleared", wordCnt, 0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("t2_dir", dir, 0);
    sendWord(16'h0001, 8, 1'b0);
    repeat (3) tick();
    sendWord(16'h0080, 8, 1'b0);
    repeat (3) tick();
    checkOutput("t2_ovf_before", ovf, 0);
    sendWord(16'h00FF, 8, 1'b0);
    checkOutput("t2_ovf", ovf, 1);
    checkOutput("t2_cnt", wordCnt, 3);
    endFrame();
    checkOutput("t2_head0", data, 8'h01);
    dataRdy = 1'b1;
    tick();
    checkOutput("t2_head1", data, 8'h80);
    checkOutput("t2_vld1", dataVld, 1);
    tick();
    checkOutput("t2_empty", dataVld, 0);
    dataRdy = 1'b0;
    ovfClr = 1'b1;
    tick();
    ovfClr = 1'b0;
    checkOutput("t2_ovf_clr", ovf, 0);

    // Frame aborted five bits into the second word
    frmBase = frmEndCount;
    startFrame();
    applyStimulus(1'b1, 1'b0);
    sendWord(16'h00C3, 8, 1'b0);
    sendWord(16'h001F, 5, 1'b0);
    endFrame();
    checkOutput("t3_frm_end", frmEnd, 1);
    checkOutput("t3_cnt", wordCnt, 1);
    checkOutput("t3_head", data, 8'hC3);
    tick();
    checkOutput("t3_frm_end_once", frmEndCount - frmBase, 1);
    dataRdy = 1'b1;
    tick();
    dataRdy = 1'b0;
    checkOutput("t3_no_partial", dataVld, 0);

    // Full FIFO with the pop landing in the last-bit rise cycle
    startFrame();
    applyStimulus(1'b1, 1'b0);
    sendWord(16'h0011, 8, 1'b0);
    sendWord(16'h0022, 8, 1'b0);
    sendWord(16'h0033, 8, 1'b1);
    checkOutput("t4_no_ovf", ovf, 0);
    checkOutput("t4_head", data, 8'h22);
    checkOutput("t4_cnt", wordCnt, 3);
    dataRdy = 1'b1;
    tick();
    checkOutput("t4_tail", data, 8'h33);
    tick();
    checkOutput("t4_empty", dataVld, 0);
    dataRdy = 1'b0;
    endFrame();

    // Reset mid-word with a word still queued
    startFrame();
    applyStimulus(1'b1, 1'b0);
    sendWord(16'h0077, 8, 1'b0);
    sendWord(16'h000A, 4, 1'b0);
    checkOutput("t5_pre_vld", dataVld, 1);
    rst = 1'b1;
    #1;
    checkOutput("t5_busy", busy, 0);
    checkOutput("t5_data_vld", dataVld, 0);
    checkOutput("t5_data", data, 0);
    checkOutput("t5_dir", dir, 0);
    checkOutput("t5_cnt", wordCnt, 0);
    checkOutput("t5_frm_end", frmEnd, 0);
    csN = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    repeat (2) tick();
    checkOutput("t5_idle_after", busy, 0);
    startFrame();
    applyStimulus(1'b0, 1'b0);
    checkOutput("t5_dir_vld", dirVld, 1);
    sendWord(16'h003C, 8, 1'b0);
    checkOutput("t5_data_new", data, 8'h3C);
    checkOutput("t5_vld_new", dataVld, 1);
    checkOutput("t5_cnt_new", wordCnt, 1);
    endFrame();
    dataRdy = 1'b1;
    tick();
    dataRdy = 1'b0;

    // 257 words with consumer ready: counter saturates, no overflow
    dataRdy = 1'b1;
    startFrame();
    applyStimulus(1'b1, 1'b0);
    for (int w = 0; w < 257; w++) sendWord(16'(w & 8'hFF), 8, 1'b0);
    checkOutput("t6_cnt_sat", wordCnt, 255);
    checkOutput("t6_no_ovf", ovf, 0);
    endFrame();
    checkOutput("t6_drained", dataVld, 0);
    dataRdy = 1'b0;

    // 16-bit instance, read, 0x1234 at clk/2
    cs16N = 1'b0;
    repeat (3) tick();
    applyStimulus(1'b0, 1'b0);
    checkOutput("t7_dir_vld", dirVld16, 1);
    checkOutput("t7_dir", dir16, 0);
    sendWord(16'h1234, 16, 1'b0);
    checkOutput("t7_data", data16, 16'h1234);
    checkOutput("t7_vld", dataVld16, 1);
    checkOutput("t7_cnt", wordCnt16, 1);
    cs16N = 1'b1;
    repeat (2) tick();
    checkOutput("t7_frm_end", frmEnd16, 1);
    checkOutput("t7_other_idle", dataVld, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
